// File: rtl/skew_feeder_pkg.sv
// Shared types and helpers for the skew feeder: FSM state encoding and
// the lane-slice helper used to locate one lane inside a packed vector.
package feeder_pkg;

  // Feeder stream states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } feeder_state_t;

  // Default element width, matching the PE operand width.
  localparam int unsigned FEEDER_DEFAULT_BW = 8;

  // Lowest bit of lane 'lane' in a packed vector of 'width'-bit elements.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/skew_feeder_if.sv
// Upstream vector handshake plus the skewed lane outputs of the feeder.
//
// Handshake: a vector transfers on a rising edge where valid and ready are
// both high, and only then. data and last are meaningful only while valid
// is high; the producer may raise valid at any time and the feeder never
// waits on valid before driving ready. last is ignored unless the transfer
// actually happens.
interface skew_feeder_if #(
  parameter int BW = 8,
  parameter int N  = 4
);
  logic          valid;
  logic [N*BW-1:0] data;
  logic          last;
  logic          ready;
  logic [N*BW-1:0] lane;
  logic          active;
  logic          done;

  // Upstream producer / PE-side consumer view.
  modport master (output valid, data, last, input ready, lane, active, done);
  // Feeder view.
  modport slave  (input valid, data, last, output ready, lane, active, done);
endinterface

// File: rtl/skew_line.sv
// Fixed-depth, reset-to-zero shift register: one per lane, depth sets the
// diagonal skew of that lane.
module skew_line #(
  parameter int BW    = 8,
  parameter int DEPTH = 1
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic [BW-1:0] i_din,
  output logic [BW-1:0] o_dout
);

  logic [DEPTH-1:0][BW-1:0] r_shift;

  // Shift one stage every cycle; reset flushes the whole line to zero.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_shift <= '0;
    end else begin
      r_shift[0] <= i_din;
      for (int k = 1; k < DEPTH; k++) begin
        r_shift[k] <= r_shift[k-1];
      end
    end
  end

  assign o_dout = r_shift[DEPTH-1];

endmodule

// File: rtl/skew_feeder.sv
// Skew feeder: accepts N-lane operand vectors and presents lane j delayed by
// j+1 cycles, forming the diagonal wavefront a systolic PE array expects.
// After the last vector it refuses input for N cycles while the wavefront
// drains, pulsing o_done when the final element leaves lane N-1.
module skew_feeder
  import feeder_pkg::*;
#(
  parameter int BW = 8,
  parameter int N  = 4
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_valid,
  input  logic [N*BW-1:0] i_data,
  input  logic            i_last,
  output logic            o_ready,
  output logic [N*BW-1:0] o_lane,
  output logic            o_active,
  output logic            o_done,
  output feeder_state_t   o_state
);

  localparam int CW = $clog2(N);

  feeder_state_t   r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_ready;
  logic            r_active;
  logic            r_done;
  logic            w_accept;
  logic [N*BW-1:0] w_lane_in;

  assign w_accept = i_valid && r_ready;
  // Idle cycles inject zeros so the lanes stay mutually aligned.
  assign w_lane_in = w_accept ? i_data : '0;

  for (genvar j = 0; j < N; j++) begin : g_lane
    skew_line #(
      .BW   (BW),
      .DEPTH(j + 1)
    ) u_line (
      .i_clock(i_clock),
      .i_reset(i_reset),
      .i_din  (w_lane_in[lane_lo(j, BW) +: BW]),
      .o_dout (o_lane[lane_lo(j, BW) +: BW])
    );
  end

  // Stream FSM with registered ready/active/done; done is raised on the
  // edge that moves the flush counter to zero, i.e. for the final FLUSH cycle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_ready  <= 1'b1;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, STREAM: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_active <= 1'b1;
            if (i_last) begin
              r_state <= FLUSH;
              r_cnt   <= CW'(N - 1);
              r_ready <= 1'b0;
            end else begin
              r_state <= STREAM;
            end
          end
        end
        FLUSH: begin
          if (r_cnt == '0) begin
            r_state  <= IDLE;
            r_ready  <= 1'b1;
            r_active <= 1'b0;
            r_done   <= 1'b0;
          end else begin
            r_cnt  <= r_cnt - 1'b1;
            r_done <= (r_cnt == CW'(1));
          end
        end
        default: begin
          r_state  <= IDLE;
          r_cnt    <= '0;
          r_ready  <= 1'b1;
          r_active <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready  = r_ready;
  assign o_active = r_active;
  assign o_done   = r_done;
  assign o_state  = r_state;

endmodule
